// File: rtl/activation_if.sv
// rtl/activation_if.sv - argument, result, error and feedback channels of the activation unit
interface activation_if #(
  parameter int ARG_W = 16,
  parameter int RES_W = 8,
  parameter int ERR_W = 16,
  parameter int DEPTH = 4
);
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              arg_stb;
  logic [ARG_W-1:0]  arg_dat;
  logic              arg_rdy;
  logic              res_stb;
  logic [RES_W-1:0]  res_dat;
  logic              res_rdy;
  logic              err_stb;
  logic [ERR_W-1:0]  err_dat;
  logic              err_rdy;
  logic              fbk_stb;
  logic [ERR_W-1:0]  fbk_dat;
  logic              fbk_rdy;
  logic [PEND_W-1:0] pend;

  // Producer of arguments and errors, consumer of results and feedback
  modport master (
    output en, arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    input  arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat, pend
  );

  // The activation unit itself
  modport slave (
    input  en, arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    output arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat, pend
  );
endinterface

// File: rtl/activation.sv
// rtl/activation.sv - heaviside / saturating ReLU activation with derivative history for backprop
module activation #(
  parameter int ARG_W = 16,
  parameter int RES_W = 8,
  parameter int ERR_W = 16,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input logic       clk,
  input logic       rst_n,
  activation_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    FULL    = PW'(DEPTH);
  localparam logic [ARG_W-1:0] SAT_ARG = {{(ARG_W-RES_W){1'b0}}, {RES_W{1'b1}}};

  logic             res_stb_q;
  logic [RES_W-1:0] res_dat_q;
  logic             fbk_stb_q;
  logic [ERR_W-1:0] fbk_dat_q;
  logic [PW-1:0]    pend_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [DEPTH-1:0] fifo_q;

  logic             arg_neg;
  logic             arg_pos;
  logic             arg_sat;
  logic [RES_W-1:0] res_d;
  logic             deriv_d;
  logic             arg_rdy;
  logic             err_rdy;
  logic             arg_ack;
  logic             push;
  logic             pop;

  // Activation function and its derivative bit for the argument on the bus
  always_comb begin
    arg_neg = bus.arg_dat[ARG_W-1];
    arg_pos = !arg_neg && (bus.arg_dat != '0);
    arg_sat = $signed(bus.arg_dat) >= $signed(SAT_ARG);
    res_d   = '0;
    deriv_d = 1'b0;
    if (MODE == 0) begin
      res_d   = arg_neg ? '0 : '1;
      deriv_d = 1'b1;
    end else begin
      if (!arg_pos)     res_d = '0;
      else if (arg_sat) res_d = '1;
      else              res_d = bus.arg_dat[RES_W-1:0];
      deriv_d = arg_pos;
    end
  end

  // Handshake readiness: a full history only blocks arguments that would be recorded
  always_comb begin
    arg_rdy = (!res_stb_q || bus.res_rdy) && (!bus.en || (pend_q != FULL));
    err_rdy = (pend_q != '0) && (!fbk_stb_q || bus.fbk_rdy);
    arg_ack = bus.arg_stb && arg_rdy;
    push    = arg_ack && bus.en;
    pop     = bus.err_stb && err_rdy;
  end

  // Result register: loads on argument ack, otherwise holds until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
    end else if (arg_ack) begin
      res_stb_q <= 1'b1;
      res_dat_q <= res_d;
    end else if (bus.res_rdy) begin
      res_stb_q <= 1'b0;
    end
  end

  // Feedback register: error gated by the oldest recorded derivative bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbk_stb_q <= 1'b0;
      fbk_dat_q <= '0;
    end else if (pop) begin
      fbk_stb_q <= 1'b1;
      fbk_dat_q <= fifo_q[rd_ptr_q] ? bus.err_dat : '0;
    end else if (bus.fbk_rdy) begin
      fbk_stb_q <= 1'b0;
    end
  end

  // Derivative history FIFO; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= deriv_d;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign bus.arg_rdy = arg_rdy;
  assign bus.err_rdy = err_rdy;
  assign bus.res_stb = res_stb_q;
  assign bus.res_dat = res_dat_q;
  assign bus.fbk_stb = fbk_stb_q;
  assign bus.fbk_dat = fbk_dat_q;
  assign bus.pend    = pend_q;
endmodule
